// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by the alu controller and its users
package alu_pkg;

    localparam logic [2:0] OPR_LOAD = 3'b000;
    localparam logic [2:0] OPR_SUB  = 3'b001;
    localparam logic [2:0] OPR_ADD  = 3'b010;
    localparam logic [2:0] OPR_XOR  = 3'b011;
    localparam logic [2:0] OPR_ASR  = 3'b100;
    localparam logic [2:0] OPR_SHL  = 3'b101;
    localparam logic [2:0] OPR_AND  = 3'b110;
    localparam logic [2:0] OPR_OR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: accumulator sequencer that repeats one alu opcode cmd_rep+1 times per command
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [W-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_rep,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [2:0]    alu_opr,
    input  logic [W-1:0]  alu_r,
    input  logic          alu_co,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  res_data,
    output logic          res_co,
    output logic          res_cany
);

    state_e        r_state;
    state_e        w_next;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_opnd;
    logic [2:0]    r_opr;
    logic [CW-1:0] r_cnt;
    logic          r_co;
    logic          r_cany;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state: leave EXEC once the remaining-iteration counter has reached zero
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = cmd_valid ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_next = (r_cnt == '0) ? ST_DONE : ST_EXEC;
            ST_DONE: w_next = res_ready ? ST_IDLE : ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only, so no comb path from cmd_valid/res_ready
    always_comb begin
        cmd_ready = (r_state == ST_IDLE);
        res_valid = (r_state == ST_DONE);
    end

    // Command latch in IDLE; one alu iteration per EXEC cycle; counter stops at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_opr  <= OPR_LOAD;
            r_cnt  <= '0;
            r_co   <= 1'b0;
            r_cany <= 1'b0;
        end else if (r_state == ST_IDLE && cmd_valid) begin
            r_opnd <= cmd_data;
            r_opr  <= cmd_op;
            r_cnt  <= cmd_rep;
            r_cany <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_acc  <= alu_r;
            r_co   <= alu_co;
            r_cany <= r_cany | alu_co;
            r_cnt  <= (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
        end
    end

    assign alu_a    = r_acc;
    assign alu_b    = r_opnd;
    assign alu_opr  = r_opr;
    assign res_data = r_acc;
    assign res_co   = r_co;
    assign res_cany = r_cany;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: scoreboard bench for alu_ctrl with a behavioural alu closing the loop
module tb_alu_ctrl;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       co;
        logic       cany;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [3:0] cmd_rep = 4'd0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_opr;
    logic [7:0] alu_r;
    logic       alu_co;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_co;
    logic       res_cany;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] m_acc = 8'h00;

    alu_ctrl #(.W(8), .CW(4)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rep(cmd_rep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opr(alu_opr),
        .alu_r(alu_r), .alu_co(alu_co),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_co(res_co), .res_cany(res_cany)
    );

    always #5 clock = ~clock;

    function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OPR_LOAD: return {1'b0, b};
            OPR_SUB:  return {1'b0, a} - {1'b0, b};
            OPR_ADD:  return {1'b0, a} + {1'b0, b};
            OPR_XOR:  return {1'b0, a ^ b};
            OPR_ASR:  return {1'b0, a[7], a[7:1]};
            OPR_SHL:  return {1'b0, a[6:0], 1'b0};
            OPR_AND:  return {1'b0, a & b};
            default:  return {1'b0, a | b};
        endcase
    endfunction

    assign {alu_co, alu_r} = alu_f(alu_opr, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // called at a negedge in IDLE; returns at the negedge of the first EXEC cycle
    task automatic issue(input logic [2:0] op, input logic [7:0] d, input logic [3:0] rep);
        int n = 0;
        cmd_op = op;
        cmd_data = d;
        cmd_rep = rep;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("hs_timeout", 32'(n < 20), 1);
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input logic [3:0] rep);
        int   n = 1;
        exp_t e;
        while (!res_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("latency", 32'(n), 32'(int'(rep) + 2));
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
            e = sb.pop_front();
            chk("res_data", 32'(res_data), 32'(e.d));
            chk("res_co", 32'(res_co), 32'(e.co));
            chk("res_cany", 32'(res_cany), 32'(e.cany));
        end
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        chk("back_idle", 32'(cmd_ready), 1);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] d, input logic [3:0] rep,
                           input logic [7:0] ed, input logic eco, input logic ecany);
        sb.push_back('{d: ed, co: eco, cany: ecany});
        m_acc = ed;
        issue(op, d, rep);
        collect(rep);
        release_res();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [7:0] d;
        logic [3:0] rep;
        logic [8:0] r;
        logic [7:0] a;
        logic       cany;
        logic       co;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_valid", 32'(res_valid), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_opr", 32'(alu_opr), 0);
        chk("rst_a", 32'(alu_a), 0);
        chk("rst_b", 32'(alu_b), 0);
        chk("rst_res", 32'({res_data, res_co, res_cany}), 0);
        chk("rst_ready2", 32'(cmd_ready), 1);
        chk("rst_valid2", 32'(res_valid), 0);

        run_cmd(OPR_LOAD, 8'h05, 4'd0, 8'h05, 1'b0, 1'b0);
        run_cmd(OPR_ADD,  8'h03, 4'd2, 8'h0E, 1'b0, 1'b0);
        run_cmd(OPR_LOAD, 8'hF0, 4'd0, 8'hF0, 1'b0, 1'b0);
        run_cmd(OPR_ADD,  8'h20, 4'd0, 8'h10, 1'b1, 1'b1);
        run_cmd(OPR_LOAD, 8'h02, 4'd0, 8'h02, 1'b0, 1'b0);
        run_cmd(OPR_SUB,  8'h03, 4'd0, 8'hFF, 1'b1, 1'b1);
        run_cmd(OPR_LOAD, 8'h81, 4'd0, 8'h81, 1'b0, 1'b0);
        run_cmd(OPR_ASR,  8'h00, 4'd3, 8'hF8, 1'b0, 1'b0);
        run_cmd(OPR_LOAD, 8'hFF, 4'd0, 8'hFF, 1'b0, 1'b0);
        run_cmd(OPR_ADD,  8'h01, 4'd1, 8'h01, 1'b0, 1'b1);
        run_cmd(OPR_LOAD, 8'h00, 4'd0, 8'h00, 1'b0, 1'b0);
        run_cmd(OPR_ADD,  8'h01, 4'd15, 8'h10, 1'b0, 1'b0);
        run_cmd(OPR_SHL,  8'h00, 4'd15, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            rep = 4'($urandom_range(0, 3));
            a = m_acc;
            co = 1'b0;
            cany = 1'b0;
            for (int k = 0; k <= int'(rep); k++) begin
                r = alu_f(op, a, d);
                a = r[7:0];
                co = r[8];
                cany = cany | co;
            end
            run_cmd(op, d, rep, a, co, cany);
        end

        sb.push_back('{d: 8'h3C, co: 1'b0, cany: 1'b0});
        issue(OPR_LOAD, 8'h3C, 4'd0);
        collect(4'd0);
        cmd_op = OPR_ADD;
        cmd_data = 8'h01;
        cmd_rep = 4'd0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_ready", 32'(cmd_ready), 0);
            chk("bp_data", 32'({res_data, res_co, res_cany}), 32'({8'h3C, 2'b00}));
            chk("bp_acc", 32'(alu_a), 32'h3C);
        end
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("bp_idle_ready", 32'(cmd_ready), 1);
        chk("bp_idle_valid", 32'(res_valid), 0);
        chk("bp_idle_acc", 32'(alu_a), 32'h3C);
        @(negedge clock);
        chk("bp_no_accept", 32'(cmd_ready), 1);
        m_acc = 8'h3C;

        run_cmd(OPR_LOAD, 8'h10, 4'd0, 8'h10, 1'b0, 1'b0);
        issue(OPR_ADD, 8'h01, 4'd15);
        @(negedge clock);
        @(negedge clock);
        chk("mid_acc", 32'(alu_a), 32'h12);
        chk("mid_busy", 32'(cmd_ready), 0);
        reset = 1'b1;
        #1;
        chk("arst_ready", 32'(cmd_ready), 1);
        chk("arst_valid", 32'(res_valid), 0);
        chk("arst_a", 32'(alu_a), 0);
        chk("arst_opr", 32'(alu_opr), 0);
        @(negedge clock);
        reset = 1'b0;
        m_acc = 8'h00;
        run_cmd(OPR_OR, 8'h5A, 4'd0, 8'h5A, 1'b0, 1'b0);

        chk("sb_left", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
